// File: rtl/alu_ctrl_pkg.sv
// Shared types, frame geometry and frame-builder helpers for the ALU serial-input path.
package alu_ctrl_pkg;

    localparam int unsigned FRAME_BITS = 99;
    localparam int unsigned WORD_BITS  = 11;
    localparam int unsigned DATA_BITS  = 4 * WORD_BITS;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101,
        OP_NOP = 3'b111
    } operation_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } arb_state_t;

    // Op is kept as raw bits so illegal codes pass through untouched.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        crc_err;
    } alu_cmd_t;

    function automatic logic [DATA_BITS-1:0] data_bits(input logic [31:0] x);
        return {2'b00, x[31:24], 1'b1, 2'b00, x[23:16], 1'b1,
                2'b00, x[15:8],  1'b1, 2'b00, x[7:0],   1'b1};
    endfunction

    function automatic logic [WORD_BITS-1:0] ctl_bits(input logic [7:0] c);
        return {2'b01, c, 1'b1};
    endfunction

    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [31:0] a,
                                                          input logic [31:0] b,
                                                          input logic [2:0]  op,
                                                          input logic [3:0]  crc);
        return {data_bits(b), data_bits(a), ctl_bits({1'b0, op, crc})};
    endfunction

endpackage

// File: rtl/alu_crc4.sv
// Parallel CRC-4 (x^4+x+1, init 0) over {B, A, 1'b1, op}, MSB first.
module alu_crc4 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [3:0]  crc
);

    logic [67:0] msg;

    assign msg = {b, a, 1'b1, op};

    always_comb begin
        crc = 4'b0000;
        for (int i = 67; i >= 0; i--) begin
            crc = {crc[2:0], 1'b0} ^ (((crc[3] ^ msg[i]) == 1'b1) ? 4'b0011 : 4'b0000);
        end
    end

endmodule

// File: rtl/alu_sin_arbiter.sv
// Round-robin arbiter sharing the ALU sin line between N_REQ requesters;
// serializes one 99-bit frame per grant followed by an idle gap.
module alu_sin_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned GAP_CYCLES = 60,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [32*N_REQ-1:0]  req_a,
    input  logic [32*N_REQ-1:0]  req_b,
    input  logic [3*N_REQ-1:0]   req_op,
    input  logic [N_REQ-1:0]     req_crc_err,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 sin,
    output logic                 busy,
    output logic [2:0]           grant_id,
    output logic [CNT_W-1:0]     frames_sent
);

    localparam int unsigned BIT_W = 7;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    arb_state_t             state;
    logic [2:0]             rr_ptr;
    alu_cmd_t               cmd_q;
    logic [FRAME_BITS-1:0]  shift_q;
    logic [BIT_W-1:0]       bit_cnt;
    logic [GAP_W-1:0]       gap_cnt;

    logic [7:0]             valid_pad_c;
    logic [3:0]             cand_c;
    logic [2:0]             pick_c;
    logic                   pick_vld_c;
    alu_cmd_t               sel_cmd_c;
    logic [3:0]             crc_c;
    logic [3:0]             tx_crc_c;

    assign valid_pad_c = 8'(req_valid);

    // Walk from the farthest candidate to rr_ptr so the nearest valid one wins.
    always_comb begin
        cand_c     = '0;
        pick_c     = '0;
        pick_vld_c = 1'b0;
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            cand_c = 4'(rr_ptr) + 4'(k);
            if (cand_c >= 4'(N_REQ)) begin
                cand_c = cand_c - 4'(N_REQ);
            end
            if (valid_pad_c[cand_c[2:0]]) begin
                pick_c     = cand_c[2:0];
                pick_vld_c = 1'b1;
            end
        end
    end

    always_comb begin
        sel_cmd_c = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (3'(i) == pick_c) begin
                sel_cmd_c.a       = req_a[32*i +: 32];
                sel_cmd_c.b       = req_b[32*i +: 32];
                sel_cmd_c.op      = req_op[3*i +: 3];
                sel_cmd_c.crc_err = req_crc_err[i];
            end
        end
    end

    alu_crc4 u_crc (
        .a   (cmd_q.a),
        .b   (cmd_q.b),
        .op  (cmd_q.op),
        .crc (crc_c)
    );

    assign tx_crc_c = crc_c + 4'(cmd_q.crc_err);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            cmd_q       <= '0;
            shift_q     <= '0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            req_ready   <= '0;
            sin         <= 1'b1;
            busy        <= 1'b0;
            grant_id    <= '0;
            frames_sent <= '0;
        end else begin
            req_ready <= '0;
            case (state)
                ST_IDLE: begin
                    sin <= 1'b1;
                    if (pick_vld_c) begin
                        cmd_q     <= sel_cmd_c;
                        grant_id  <= pick_c;
                        req_ready <= N_REQ'(8'd1 << pick_c);
                        busy      <= 1'b1;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    shift_q <= build_frame(cmd_q.a, cmd_q.b, cmd_q.op, tx_crc_c);
                    bit_cnt <= '0;
                    rr_ptr  <= (grant_id == 3'(N_REQ - 1)) ? 3'd0 : grant_id + 3'd1;
                    state   <= ST_SEND;
                end
                ST_SEND: begin
                    // sin is registered, so it trails shift_q by one clock.
                    sin     <= shift_q[FRAME_BITS-1];
                    shift_q <= {shift_q[FRAME_BITS-2:0], 1'b0};
                    bit_cnt <= bit_cnt + BIT_W'(1);
                    if (bit_cnt == BIT_W'(FRAME_BITS - 1)) begin
                        gap_cnt     <= '0;
                        frames_sent <= frames_sent + CNT_W'(1);
                        state       <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    sin <= 1'b1;
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    sin   <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sin_arbiter.sv
// Scoreboard bench for alu_sin_arbiter: stimulus pushes expected frames, a sin monitor pops and compares.
`timescale 1ns/1ps
module tb_alu_sin_arbiter;
    import alu_ctrl_pkg::*;

    localparam int unsigned GAP = 60;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid;
    logic [63:0] req_a, req_b;
    logic [5:0]  req_op;
    logic [1:0]  req_crc_err;
    logic [1:0]  req_ready;
    logic        sin, busy;
    logic [2:0]  grant_id;
    logic [15:0] frames_sent;

    logic        w_valid, w_err, w_ready, w_sin, w_busy;
    logic [31:0] w_a, w_b;
    logic [2:0]  w_op, w_gid;
    logic [3:0]  w_cnt;

    always #5 clk = ~clk;

    alu_sin_arbiter #(.N_REQ(2), .GAP_CYCLES(GAP), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_op(req_op), .req_crc_err(req_crc_err), .req_ready(req_ready), .sin(sin),
        .busy(busy), .grant_id(grant_id), .frames_sent(frames_sent)
    );

    alu_sin_arbiter #(.N_REQ(1), .GAP_CYCLES(2), .CNT_W(4)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .req_valid(w_valid), .req_a(w_a), .req_b(w_b),
        .req_op(w_op), .req_crc_err(w_err), .req_ready(w_ready), .sin(w_sin),
        .busy(w_busy), .grant_id(w_gid), .frames_sent(w_cnt)
    );

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    logic [98:0] exp_frame_q[$];
    logic [2:0]  exp_gid_q[$];
    string       exp_name_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Remainder of M(x)*x^4 mod (x^4+x+1) by long division.
    function automatic logic [3:0] crc_model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        logic [71:0] r;
        r = {b, a, 1'b1, op, 4'b0000};
        for (int i = 71; i >= 4; i--) begin
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        end
        return r[3:0];
    endfunction

    function automatic logic [98:0] frame_model(input logic [31:0] a, input logic [31:0] b,
                                                input logic [2:0] op, input logic [3:0] crc);
        logic [98:0] f;
        logic [10:0] word;
        f = '0;
        for (int w = 0; w < 9; w++) begin
            if (w < 4)      word = {2'b00, b[31-8*w -: 8], 1'b1};
            else if (w < 8) word = {2'b00, a[31-8*(w-4) -: 8], 1'b1};
            else            word = {2'b01, 1'b0, op, crc, 1'b1};
            f[98-11*w -: 11] = word;
        end
        return f;
    endfunction

    task automatic expect_frame(input string name, input logic [98:0] f, input logic [2:0] gid);
        exp_frame_q.push_back(f);
        exp_gid_q.push_back(gid);
        exp_name_q.push_back(name);
    endtask

    task automatic issue(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic err);
        req_a[32*r +: 32] = a;
        req_b[32*r +: 32] = b;
        req_op[3*r +: 3]  = op;
        req_crc_err[r]    = err;
        req_valid[r]      = 1'b1;
    endtask

    task automatic wait_ready(input string name, input logic [1:0] want);
        int n = 0;
        @(negedge clk);
        while (req_ready === 2'b00 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, "_ready"}, 128'(req_ready), 128'(want));
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, 128'(busy), 128'(1'b0));
    endtask

    // sin monitor: capture a frame from its start bit, compare against the scoreboard.
    logic [98:0] cap;
    logic [2:0]  cap_gid;
    int          nbits = 0;
    int          last_start = -1;
    bit          spacing_on = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            nbits      = 0;
            last_start = -1;
        end else if (nbits == 0) begin
            if (sin === 1'b0) begin
                cap     = '0;
                cap_gid = grant_id;
                nbits   = 1;
                if (spacing_on && last_start >= 0)
                    check("start_spacing", 128'(cyc - last_start), 128'(101 + GAP));
                last_start = cyc;
            end
        end else begin
            cap[98-nbits] = sin;
            nbits++;
            if (nbits == 99) begin
                nbits = 0;
                if (exp_frame_q.size() == 0) begin
                    check("unexpected_frame", 128'(cap), 128'(0));
                end else begin
                    string nm;
                    nm = exp_name_q.pop_front();
                    check({nm, "_frame"}, 128'(cap), 128'(exp_frame_q.pop_front()));
                    check({nm, "_gid"}, 128'(cap_gid), 128'(exp_gid_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ta0, tb0, ta1, tb1;
        int issue_cyc, cnt, n;
        req_valid = '0; req_a = '0; req_b = '0; req_op = '0; req_crc_err = '0;
        w_valid = 1'b0; w_a = 32'h0BADF00D; w_b = 32'h00000042; w_op = OP_ADD; w_err = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_sin", 128'(sin), 128'(1'b1));
        check("rst_busy", 128'(busy), 128'(1'b0));
        check("rst_ready", 128'(req_ready), 128'(2'b00));
        check("rst_grant", 128'(grant_id), 128'(3'd0));
        check("rst_frames", 128'(frames_sent), 128'(16'd0));
        rst_n = 1'b1;
        @(negedge clk);

        // Single all-zero request, hand-computed CRC 1011.
        expect_frame("t1", {{8{11'b00_00000000_1}}, 11'b01_0_000_1011_1}, 3'd0);
        issue(0, 32'h0, 32'h0, OP_AND, 1'b0);
        issue_cyc = cyc;
        wait_ready("t1", 2'b01);
        req_valid = '0;
        @(negedge clk);
        check("t1_ready_width", 128'(req_ready), 128'(2'b00));
        wait_idle("t1");
        check("t1_start_latency", 128'(last_start - issue_cyc), 128'(3));
        check("t1_frames_sent", 128'(frames_sent), 128'(16'd1));

        // Same command with CRC error injection: CRC 1011 + 1 = 1100.
        expect_frame("t2", {{8{11'b00_00000000_1}}, 11'b01_0_000_1100_1}, 3'd0);
        issue(0, 32'h0, 32'h0, OP_AND, 1'b1);
        wait_ready("t2", 2'b01);
        req_valid = '0;
        wait_idle("t2");
        check("t2_frames_sent", 128'(frames_sent), 128'(16'd2));

        // Two continuous requesters after reset: grants 0,1,0,1.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ta0 = 32'h12345678; tb0 = 32'h9ABCDEF0; ta1 = 32'hDEADBEEF; tb1 = 32'h00C0FFEE;
        for (int k = 0; k < 2; k++) begin
            expect_frame("t3_r0", frame_model(ta0, tb0, OP_ADD, crc_model(ta0, tb0, OP_ADD)), 3'd0);
            expect_frame("t3_r1", frame_model(ta1, tb1, OP_SUB, crc_model(ta1, tb1, OP_SUB)), 3'd1);
        end
        spacing_on = 1'b1;
        issue(0, ta0, tb0, OP_ADD, 1'b0);
        issue(1, ta1, tb1, OP_SUB, 1'b0);
        for (int k = 0; k < 4; k++) begin
            wait_ready("t3", (k % 2 == 0) ? 2'b01 : 2'b10);
        end
        req_valid = '0;
        wait_idle("t3");
        spacing_on = 1'b0;
        check("t3_frames_sent", 128'(frames_sent), 128'(16'd4));

        // Reset in the middle of a frame; frame is abandoned.
        issue(0, 32'hA5A5A5A5, 32'h5A5A5A5A, OP_OR, 1'b0);
        wait_ready("t4_pre", 2'b01);
        req_valid = '0;
        n = 0;
        while (sin !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t4_start_seen", 128'(sin), 128'(1'b0));
        repeat (40) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_async_sin", 128'(sin), 128'(1'b1));
        check("t4_async_busy", 128'(busy), 128'(1'b0));
        check("t4_async_frames", 128'(frames_sent), 128'(16'd0));
        check("t4_async_grant", 128'(grant_id), 128'(3'd0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fresh grant goes to req0, then req1 carries illegal op 111.
        ta0 = 32'h01020304; tb0 = 32'hF0E0D0C0;
        expect_frame("t4_fresh", frame_model(ta0, tb0, OP_OR, crc_model(ta0, tb0, OP_OR)), 3'd0);
        expect_frame("t5_op7", frame_model(32'hFFFFFFFF, 32'h0, 3'b111,
                                           crc_model(32'hFFFFFFFF, 32'h0, 3'b111)), 3'd1);
        issue(0, ta0, tb0, OP_OR, 1'b0);
        issue(1, 32'hFFFFFFFF, 32'h0, 3'b111, 1'b0);
        wait_ready("t4_fresh", 2'b01);
        req_valid[0] = 1'b0;
        wait_ready("t5", 2'b10);
        req_valid[1] = 1'b0;
        wait_idle("t5");
        check("t5_frames_sent", 128'(frames_sent), 128'(16'd2));

        // Narrow counter wraps: 17 frames on a 4-bit counter reads 1.
        cnt = 0;
        n = 0;
        w_valid = 1'b1;
        while (cnt < 17 && n < 4000) begin
            @(negedge clk);
            n++;
            if (w_ready === 1'b1) cnt++;
            if (cnt == 17) w_valid = 1'b0;
        end
        w_valid = 1'b0;
        check("t6_ready_count", 128'(cnt), 128'(17));
        n = 0;
        while (w_busy !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("t6_wrap_count", 128'(w_cnt), 128'(4'd1));
        check("t6_fixed_grant", 128'(w_gid), 128'(3'd0));

        repeat (2) @(negedge clk);
        check("queue_drained", 128'(exp_frame_q.size()), 128'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
